// File: rtl/potential_decay_unit_pkg.sv
// Shared constants and types for the potential decay unit.
//   INPUT_W   : adder operand width
//   PW        : membrane potential width (adder sum width)
//   LEAK_W    : leak amount width
//   PERIOD_W  : leak period / timer width
//   REFRACT_W : refractory counter width
//   pdu_state_e : RUN / REFRACT
package potential_decay_unit_pkg;
  localparam int INPUT_W   = 14;
  localparam int PW        = INPUT_W + 2;
  localparam int LEAK_W    = 8;
  localparam int PERIOD_W  = 16;
  localparam int REFRACT_W = 4;

  typedef enum logic {
    RUN     = 1'b0,
    REFRACT = 1'b1
  } pdu_state_e;
endpackage

// File: rtl/potential_decay_unit_if.sv
// Valid/ready sum stream from the carry-save adder into the decay unit.
//   valid : sum is valid this cycle (master drives)
//   ready : consumer accepts this cycle (slave drives)
//   sum   : unsigned adder output, p_pw bits
interface potential_decay_unit_if
  import potential_decay_unit_pkg::*;
#(
  parameter int p_pw = PW
) ();
  logic            valid;
  logic            ready;
  logic [p_pw-1:0] sum;

  modport master (output valid, output sum, input  ready);
  modport slave  (input  valid, input  sum, output ready);
endinterface

// File: rtl/pdu_leak_timer.sv
// Leak period counter.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_hold         : freeze the count and suppress leak events
//   i_clr          : force the count to 0 (wins over everything)
//   i_period       : cycles between leak events, 0 disables leaking
//   o_leak         : leak event this cycle (combinational)
module pdu_leak_timer
  import potential_decay_unit_pkg::*;
#(
  parameter int p_period_width = PERIOD_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_hold,
  input  logic                      i_clr,
  input  logic [p_period_width-1:0] i_period,
  output logic                      o_leak
);
  logic [p_period_width-1:0] timer;

  // timer >= period-1, written as timer+1 >= period in one extra bit so
  // no subtraction can wrap. A >= rather than == means a lowered period
  // triggers on the very next cycle instead of waiting for a wrap.
  always_comb begin
    o_leak = !i_hold && (i_period != '0) &&
             (({1'b0, timer} + 1'b1) >= {1'b0, i_period});
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     timer <= '0;
    else if (i_clr)   timer <= '0;
    else if (i_hold)  timer <= timer;
    else if (o_leak)  timer <= '0;
    else              timer <= timer + 1'b1;
  end
endmodule

// File: rtl/potential_decay_unit.sv
// Membrane potential integrator with periodic linear leak, threshold fire
// and refractory stall.
//   i_clk, i_rst_n : clock, async active-low reset
//   in_bus         : slave side of the adder sum stream (valid/ready/sum)
//   i_leak         : amount subtracted on each leak event
//   i_period       : cycles between leak events, 0 = leak disabled
//   i_threshold    : fire threshold, 0 = firing disabled
//   i_refract      : refractory length in cycles
//   o_potential    : potential register
//   o_spike        : one-cycle fire pulse
//   o_sat          : one-cycle pulse when an add clipped at max
module potential_decay_unit
  import potential_decay_unit_pkg::*;
#(
  parameter int p_input_width   = INPUT_W,
  parameter int p_leak_width    = LEAK_W,
  parameter int p_period_width  = PERIOD_W,
  parameter int p_refract_width = REFRACT_W
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  potential_decay_unit_if.slave      in_bus,
  input  logic [p_leak_width-1:0]    i_leak,
  input  logic [p_period_width-1:0]  i_period,
  input  logic [p_input_width+1:0]   i_threshold,
  input  logic [p_refract_width-1:0] i_refract,
  output logic [p_input_width+1:0]   o_potential,
  output logic                       o_spike,
  output logic                       o_sat
);
  localparam int W = p_input_width + 2;
  // Max potential as a PW+2 signed value for the overflow compare.
  localparam logic signed [W+1:0] POT_MAX = {2'b00, {W{1'b1}}};

  pdu_state_e                 state;
  logic [p_refract_width-1:0] rcnt;
  logic                       run, accept, leak, fire, over;
  logic signed [W+1:0]        add_term, sub_term, raw;
  logic [W-1:0]               clamped;

  assign run          = (state == RUN);
  assign in_bus.ready = run;
  assign accept       = in_bus.valid & run;

  pdu_leak_timer #(.p_period_width(p_period_width)) u_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_hold   (!run),
    .i_clr    (run & fire),
    .i_period (i_period),
    .o_leak   (leak)
  );

  // Two guard bits: the top one keeps the sum signed so an underflow is
  // visible, the next holds the carry of pot + sum.
  always_comb begin
    add_term = accept ? $signed({2'b00, in_bus.sum}) : '0;
    sub_term = leak   ? $signed((W+2)'(i_leak))      : '0;
    raw      = $signed({2'b00, o_potential}) + add_term - sub_term;
    over     = (raw > POT_MAX);
    if (raw[W+1])  clamped = '0;
    else if (over) clamped = '1;
    else           clamped = raw[W-1:0];
    fire = (i_threshold != '0) && (clamped >= i_threshold);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= RUN;
      rcnt        <= '0;
      o_potential <= '0;
      o_spike     <= 1'b0;
      o_sat       <= 1'b0;
    end else begin
      o_spike <= 1'b0;
      o_sat   <= 1'b0;
      case (state)
        RUN: begin
          o_sat <= over;
          if (fire) begin
            o_potential <= '0;
            o_spike     <= 1'b1;
            // Loading refract-1 and leaving at 0 gives exactly i_refract
            // stalled cycles.
            if (i_refract != '0) begin
              state <= REFRACT;
              rcnt  <= i_refract - 1'b1;
            end
          end else begin
            o_potential <= clamped;
          end
        end
        REFRACT: begin
          if (rcnt == '0) state <= RUN;
          else            rcnt  <= rcnt - 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_potential_decay_unit.sv
// Directed bench for potential_decay_unit.
module tb_potential_decay_unit;
  import potential_decay_unit_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic [LEAK_W-1:0]    leak;
  logic [PERIOD_W-1:0]  period;
  logic [PW-1:0]        thr;
  logic [REFRACT_W-1:0] refract;
  logic [PW-1:0]        pot;
  logic                 spike, sat;
  int                   n_chk, n_fail;

  potential_decay_unit_if #(.p_pw(PW)) bus ();

  potential_decay_unit dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .in_bus      (bus),
    .i_leak      (leak),
    .i_period    (period),
    .i_threshold (thr),
    .i_refract   (refract),
    .o_potential (pot),
    .o_spike     (spike),
    .o_sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge; done well before the next edge.
  task automatic rst_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; n_chk = 0; n_fail = 0;
    bus.valid = 1'b0; bus.sum = '0;
    leak = '0; period = '0; thr = '0; refract = '0;

    // reset state, ready high during reset
    #3;
    chk("rst_pot",   32'(pot),       0);
    chk("rst_spike", 32'(spike),     0);
    chk("rst_sat",   32'(sat),       0);
    chk("rst_ready", 32'(bus.ready), 1);
    step();
    rst_n = 1'b1;

    // plain integration, no leak, no fire
    bus.valid = 1'b1; bus.sum = 100;
    step(); chk("acc_100", 32'(pot), 100);
    bus.sum = 200;
    step(); chk("acc_300", 32'(pot), 300);
    chk("acc_spike", 32'(spike), 0);
    chk("acc_ready", 32'(bus.ready), 1);
    bus.valid = 1'b0;

    // periodic leak from 35 by 10 every 4 cycles, clamps at 0
    period = 4; leak = 10;
    rst_pulse();
    bus.valid = 1'b1; bus.sum = 35;
    step(); bus.valid = 1'b0;
    chk("lk_e1", 32'(pot), 35);
    step(); step(); chk("lk_e3", 32'(pot), 35);
    step(); chk("lk_e4", 32'(pot), 25);
    repeat (4) step(); chk("lk_e8", 32'(pot), 15);
    repeat (4) step(); chk("lk_e12", 32'(pot), 5);
    repeat (4) step(); chk("lk_e16", 32'(pot), 0);
    chk("lk_sat", 32'(sat), 0);

    // fire with refractory 3, input held valid during stall
    period = 0; leak = 0; thr = 500; refract = 3;
    rst_pulse();
    bus.valid = 1'b1; bus.sum = 450;
    step(); chk("fr_450", 32'(pot), 450);
    chk("fr_nospk", 32'(spike), 0);
    bus.sum = 60;
    step(); chk("fr_spike", 32'(spike), 1);
    chk("fr_pot0", 32'(pot), 0);
    chk("fr_rdy1", 32'(bus.ready), 0);
    bus.sum = 7;
    step(); chk("fr_spk_off", 32'(spike), 0);
    chk("fr_rdy2", 32'(bus.ready), 0);
    chk("fr_stall", 32'(pot), 0);
    step(); chk("fr_rdy3", 32'(bus.ready), 0);
    step(); chk("fr_rdy_back", 32'(bus.ready), 1);
    chk("fr_pot_hold", 32'(pot), 0);
    bus.valid = 1'b0;

    // equal to threshold fires; refract 0 keeps ready high
    thr = 300; refract = 0;
    rst_pulse();
    bus.valid = 1'b1; bus.sum = 300;
    step(); bus.valid = 1'b0;
    chk("eq_spike", 32'(spike), 1);
    chk("eq_pot", 32'(pot), 0);
    chk("eq_ready", 32'(bus.ready), 1);
    step(); chk("eq_spk_off", 32'(spike), 0);

    // accept and leak in the same cycle: 40 + 20 - 50
    thr = 0; period = 2; leak = 50;
    rst_pulse();
    bus.valid = 1'b1; bus.sum = 40;
    step(); chk("al_40", 32'(pot), 40);
    bus.sum = 20;
    step(); chk("al_10", 32'(pot), 10);
    bus.valid = 1'b0;

    // saturation at 2^PW-1
    period = 0; leak = 0;
    rst_pulse();
    bus.valid = 1'b1; bus.sum = 65500;
    step(); chk("st_65500", 32'(pot), 65500);
    chk("st_nosat", 32'(sat), 0);
    bus.sum = 100;
    step(); chk("st_max", 32'(pot), 65535);
    chk("st_sat", 32'(sat), 1);
    bus.valid = 1'b0;
    step(); chk("st_sat_off", 32'(sat), 0);
    chk("st_hold", 32'(pot), 65535);

    // async reset in the middle of a refractory interval
    thr = 500; refract = 5;
    rst_pulse();
    bus.valid = 1'b1; bus.sum = 600;
    step(); bus.valid = 1'b0;
    chk("mr_spike", 32'(spike), 1);
    chk("mr_rdy_lo", 32'(bus.ready), 0);
    step(); chk("mr_mid", 32'(bus.ready), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_rdy", 32'(bus.ready), 1);
    chk("mr_pot", 32'(pot), 0);
    chk("mr_spk", 32'(spike), 0);
    rst_n = 1'b1;
    step(); chk("mr_run", 32'(bus.ready), 1);
    chk("mr_nospk", 32'(spike), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/potential_decay_unit.md
# potential_decay_unit

Sequential consumer of the 4-input carry-save adder sum. It integrates each accepted sum into a saturating membrane-potential register and applies a periodic linear leak. When the potential reaches a threshold it emits a one-cycle spike, clears the potential and holds off input for a refractory interval. It sits directly downstream of the adder in each neuron datapath.

## Interface
- p_input_width, 14, adder operand width; potential width PW = p_input_width+2
- p_leak_width, 8, width of leak amount
- p_period_width, 16, width of leak period and leak timer
- p_refract_width, 4, width of refractory count
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  i_sum valid this cycle
- o_ready  out  1  unit accepts i_sum this cycle
- i_sum  in  PW  unsigned adder output
- i_leak  in  p_leak_width  amount subtracted per leak event
- i_period  in  p_period_width  cycles between leak events; 0 = leak disabled
- i_threshold  in  PW  fire threshold; 0 = firing disabled
- i_refract  in  p_refract_width  refractory length in cycles
- o_potential  out  PW  current potential register
- o_spike  out  1  one-cycle fire pulse
- o_sat  out  1  one-cycle pulse when an add clipped at max

## Operation
- States: RUN, REFRACT.
- Accept: handshake completes when i_valid & o_ready. o_ready = (state == RUN).
- Leak event: in RUN, when i_period != 0 and timer >= i_period-1. Otherwise the timer increments.
  - On a leak event the timer goes to 0.
  - The >= compare means that lowering i_period mid-count causes a leak on the next cycle.
- Next potential, computed in PW+2 signed bits: pot + (accept ? i_sum : 0) - (leak ? i_leak : 0).
  - Add first, then subtract, in the same cycle.
  - Clamp to [0, 2^PW-1].
  - o_sat pulses if the unclipped value exceeds 2^PW-1.
  - Underflow clamps to 0 silently.
- Fire: if i_threshold != 0 and clamped next potential >= i_threshold:
  - potential <= 0, o_spike <= 1, timer <= 0.
  - If i_refract == 0, state stays RUN; otherwise state <= REFRACT and the refractory counter <= i_refract-1.
- REFRACT:
  - Input is stalled and no leak occurs; the timer is held at 0.
  - The counter decrements each cycle; at 0 the state goes to RUN.
- Unsigned arithmetic throughout. i_leak is zero-extended.

## Timing
- Reset (asynchronous, active-low): state=RUN, o_potential=0, timer=0, refractory counter=0, o_spike=0, o_sat=0. o_ready=1 one cycle after deassertion is not required; o_ready is high during reset.
- Latency: a sum accepted at edge k is visible on o_potential after edge k (one cycle).
- o_spike and o_sat are registered and asserted for exactly one cycle after the triggering edge.
- On the spike cycle, o_potential reads 0.
- Refractory: o_ready is low for exactly i_refract cycles, starting the cycle after the fire edge.
- Accept and leak in the same cycle: both are applied, with no event dropped.
- Reset mid-REFRACT returns the unit to RUN with the potential cleared.
- Inputs i_leak, i_period, i_threshold and i_refract are sampled every cycle, and they are not latched.

## Structure
- Shared package holds:
  - the PW, leak, period and refractory width constants;
  - the state enum {RUN, REFRACT}.
- One sub-module, `pdu_leak_timer`: period counter with hold/clear inputs and a leak-event output.
- Saturating add/sub and the FSM stay in the top module.

## Test plan
- Reset, then i_period=0, i_threshold=0, push sums 100, 200 -> o_potential 100 then 300, no spike, o_ready stays 1.
- i_period=4, i_leak=10, pot=35, no input -> potential 25, 15, 5, 0 at 4-cycle intervals; clamps at 0, no o_sat.
- i_threshold=500, pot=450, push 60 -> next cycle o_spike=1, o_potential=0. With i_refract=3, o_ready is low for 3 cycles, then 1.
- Simultaneous accept of i_sum=20 and leak of i_leak=50 with pot=40 -> pot=10.
- PW=16, pot=65500, push 100 -> pot=65535, o_sat pulses once.
- Assert i_rst_n=0 during REFRACT mid-count -> immediately state RUN, pot 0, o_ready=1, no o_spike.
